// File: rtl/ssp_pkg.sv
// Shared SSP constants and state encodings, used by the TX and RX controllers.
package ssp_pkg;

   localparam int SSP_DATA_WIDTH = 8;
   localparam int SSP_CLK_DIV    = 2;
   localparam int SSP_POP_LAT    = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      FRAME  = 3'd2,
      SHIFT  = 3'd3,
      PARITY = 3'd4
   } ssp_state_t;

   // Counter width that stays legal (>=1 bit) even when only one value is needed.
   function automatic int ssp_cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ssp_tx_ctrl_if.sv
// TX sequencer bus: FIFO handshake on one side, SSP pad signals on the other.
// master = environment (FIFO, control register, pads); slave = ssp_tx_ctrl.
interface ssp_tx_ctrl_if
   import ssp_pkg::*;
#(
   parameter int DATA_WIDTH = SSP_DATA_WIDTH
);

   logic                  i_EN;
   logic                  i_TX_VALID;
   logic [DATA_WIDTH-1:0] i_TXDATA;
   logic                  o_REQ;
   logic                  o_SSPTXD;
   logic                  o_SSPCLKOUT;
   logic                  o_SSPFSSOUT;
   logic                  o_SSPOE_B;
   logic                  o_BUSY;

   modport master (
      output i_EN, i_TX_VALID, i_TXDATA,
      input  o_REQ, o_SSPTXD, o_SSPCLKOUT, o_SSPFSSOUT, o_SSPOE_B, o_BUSY
   );

   modport slave (
      input  i_EN, i_TX_VALID, i_TXDATA,
      output o_REQ, o_SSPTXD, o_SSPCLKOUT, o_SSPFSSOUT, o_SSPOE_B, o_BUSY
   );

endinterface

// File: rtl/ssp_clk_div.sv
// SSP serial clock divider: counts half periods of the serial clock, flags the
// ticks that toggle it, and owns the registered serial clock itself.
// CLK_DIV must be even and at least 2.
module ssp_clk_div
   import ssp_pkg::*;
#(
   parameter int CLK_DIV = SSP_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic rise_tick,
   output logic fall_tick,
   output logic sclk
);

   localparam int HALF = CLK_DIV / 2;
   localparam int CW   = ssp_cnt_width(HALF);
   localparam logic [CW-1:0] TERM = CW'(HALF - 1);

   logic [CW-1:0] cnt;
   logic          tick;

   assign tick      = run && (cnt == TERM);
   assign rise_tick = tick && !sclk;
   assign fall_tick = tick && sclk;

   // Half-period counter; wraps at the terminal count, held at zero when cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= (cnt == TERM) ? '0 : cnt + 1'b1;
      end
   end

   // Serial clock toggles on every tick and parks low while cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk <= 1'b0;
      end else if (clr) begin
         sclk <= 1'b0;
      end else if (tick) begin
         sclk <= ~sclk;
      end
   end

endmodule

// File: rtl/ssp_tx_ctrl.sv
// SSP transmit sequencer: pops words from the TX FIFO and sends them MSB-first
// in TI-style frames (one serial clock period of frame sync, then the data).
// Optional build macro SSP_TX_PARITY_EN appends an odd-parity bit to each word.
module ssp_tx_ctrl
   import ssp_pkg::*;
#(
   parameter int DATA_WIDTH = SSP_DATA_WIDTH,
   parameter int CLK_DIV    = SSP_CLK_DIV,
   parameter int POP_LAT    = SSP_POP_LAT
) (
   input  logic          i_PCLK,
   input  logic          i_CLEAR,
   ssp_tx_ctrl_if.slave  bus
);

   localparam int BW = ssp_cnt_width(DATA_WIDTH);
   localparam int PW = ssp_cnt_width(POP_LAT + 1);

   ssp_state_t            state;
   ssp_state_t            state_next;
   logic [DATA_WIDTH-1:0] shreg;
   logic [BW-1:0]         bit_cnt;
   logic [PW-1:0]         pop_wait;
   logic                  start_ok;
   logic                  div_clr;
   logic                  rise_tick;
   logic                  fall_tick;
   logic                  sclk;

   logic req, req_next;
   logic txd, txd_next;
   logic fss, fss_next;
   logic oe_b, oe_b_next;
   logic busy, busy_next;

   assign start_ok = bus.i_EN && bus.i_TX_VALID && (pop_wait == '0);
   assign div_clr  = (state == IDLE) || (state == LOAD);

   ssp_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .clk       (i_PCLK),
      .rst       (i_CLEAR),
      .clr       (div_clr),
      .run       (!div_clr),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick),
      .sclk      (sclk)
   );

   // State register.
   always_ff @(posedge i_PCLK or posedge i_CLEAR) begin
      if (i_CLEAR) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state plus the next value of every registered output.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start_ok) state_next = LOAD;
         end
         LOAD: begin
            state_next = FRAME;
         end
         FRAME: begin
            if (fall_tick) state_next = SHIFT;
         end
         SHIFT: begin
            if (fall_tick && (bit_cnt == '0)) begin
`ifdef SSP_TX_PARITY_EN
               state_next = PARITY;
`else
               state_next = start_ok ? LOAD : IDLE;
`endif
            end
         end
`ifdef SSP_TX_PARITY_EN
         PARITY: begin
            if (fall_tick) state_next = start_ok ? LOAD : IDLE;
         end
`endif
         default: begin
            state_next = IDLE;
         end
      endcase

      req_next  = (state == LOAD);
      fss_next  = (state_next == FRAME);
      busy_next = (state_next != IDLE);
      oe_b_next = oe_b;
      txd_next  = txd;
      case (state_next)
         IDLE: begin
            oe_b_next = 1'b1;
            txd_next  = 1'b0;
         end
         LOAD: begin
         end
         FRAME: begin
            oe_b_next = 1'b0;
            txd_next  = 1'b0;
         end
         default: begin
            oe_b_next = 1'b0;
         end
      endcase

      if ((state == SHIFT) && rise_tick) txd_next = shreg[bit_cnt];
`ifdef SSP_TX_PARITY_EN
      if ((state == PARITY) && rise_tick) txd_next = ~^shreg;
`endif
   end

   // Word capture and FIFO pop holdoff; the holdoff restarts at every pop.
   always_ff @(posedge i_PCLK or posedge i_CLEAR) begin
      if (i_CLEAR) begin
         shreg    <= '0;
         pop_wait <= '0;
      end else if (state == LOAD) begin
         shreg    <= bus.i_TXDATA;
         pop_wait <= PW'(POP_LAT);
      end else if (pop_wait != '0) begin
         pop_wait <= pop_wait - 1'b1;
      end
   end

   // Bit index: starts at the MSB when the frame sync ends, steps down per bit.
   always_ff @(posedge i_PCLK or posedge i_CLEAR) begin
      if (i_CLEAR) begin
         bit_cnt <= '0;
      end else if ((state == FRAME) && fall_tick) begin
         bit_cnt <= BW'(DATA_WIDTH - 1);
      end else if ((state == SHIFT) && fall_tick && (bit_cnt != '0)) begin
         bit_cnt <= bit_cnt - 1'b1;
      end
   end

   // Output registers, so the pads and the FIFO see glitch-free levels.
   always_ff @(posedge i_PCLK or posedge i_CLEAR) begin
      if (i_CLEAR) begin
         req  <= 1'b0;
         txd  <= 1'b0;
         fss  <= 1'b0;
         oe_b <= 1'b1;
         busy <= 1'b0;
      end else begin
         req  <= req_next;
         txd  <= txd_next;
         fss  <= fss_next;
         oe_b <= oe_b_next;
         busy <= busy_next;
      end
   end

   assign bus.o_REQ       = req;
   assign bus.o_SSPTXD    = txd;
   assign bus.o_SSPCLKOUT = sclk;
   assign bus.o_SSPFSSOUT = fss;
   assign bus.o_SSPOE_B   = oe_b;
   assign bus.o_BUSY      = busy;

endmodule
